// File: rtl/seq_pkg.sv
// Shared definitions for the serial pattern scan controller: defaults, state codes, pattern mask helper.
package seq_pkg;

  localparam int unsigned DEF_DATA_W = 16;
  localparam int unsigned DEF_PAT_W  = 4;
  localparam int unsigned MASK_MAX_W = 32;

  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] SHIFT = 2'b01;
  localparam logic [1:0] DONE  = 2'b10;

  // Low `len` bits set, i.e. (1<<len)-1, saturating at MASK_MAX_W bits.
  function automatic logic [MASK_MAX_W-1:0] mask(input int unsigned len);
    logic [MASK_MAX_W-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < MASK_MAX_W; i++) begin
      m[i] = (i < len);
    end
    return m;
  endfunction

endpackage

// File: rtl/seq_match_core.sv
// History shift register plus masked, length-qualified overlapping pattern compare.
module seq_match_core
  import seq_pkg::*;
#(
  parameter int unsigned PAT_W = DEF_PAT_W,
  parameter int unsigned LEN_W = 3,
  parameter int unsigned IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             shift_en,
  input  logic             bit_in,
  input  logic [PAT_W-1:0] pat,
  input  logic [LEN_W-1:0] pat_len,
  input  logic [IDX_W-1:0] idx,
  output logic             match_c
);

  logic [PAT_W-1:0] hist_q;
  logic [PAT_W-1:0] hist_next_c;
  logic [PAT_W-1:0] pat_mask_c;

  generate
    if (PAT_W == 1) begin : g_one
      assign hist_next_c = bit_in;
    end else begin : g_multi
      assign hist_next_c = {hist_q[PAT_W-2:0], bit_in};
    end
  endgenerate

  assign pat_mask_c = PAT_W'(mask(32'(pat_len)));

  // Match only once enough bits have been seen to fill the pattern.
  assign match_c = shift_en
                 && (((hist_next_c ^ pat) & pat_mask_c) == '0)
                 && ((32'(idx) + 32'd1) >= 32'(pat_len));

  always_ff @(posedge clk) begin
    if (rst) begin
      hist_q <= '0;
    end else if (clr) begin
      hist_q <= '0;
    end else if (shift_en) begin
      hist_q <= hist_next_c;
    end
  end

endmodule

// File: rtl/seq_scan_ctrl.sv
// Word-level scan controller: captures a word and pattern on start, shifts it MSB-first through the matcher.
module seq_scan_ctrl
  import seq_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned PAT_W  = DEF_PAT_W,
  parameter int unsigned CNT_W  = $clog2(DATA_W + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [DATA_W-1:0]            data_in,
  input  logic [PAT_W-1:0]             pat,
  input  logic [$clog2(PAT_W+1)-1:0]   pat_len,
  output logic                         busy,
  output logic                         hit,
  output logic                         done,
  output logic [CNT_W-1:0]             match_cnt,
  output logic                         err
);

  localparam int unsigned LEN_W = $clog2(PAT_W + 1);
  localparam int unsigned IDX_W = $clog2(DATA_W);

  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] word_q, word_d;
  logic [PAT_W-1:0]  pat_q, pat_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic              hit_q, hit_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              clr_c, shift_c, match_c, len_ok_c;

  assign len_ok_c = (32'(pat_len) >= 32'd1) && (32'(pat_len) <= PAT_W);

  seq_match_core #(
    .PAT_W (PAT_W),
    .LEN_W (LEN_W),
    .IDX_W (IDX_W)
  ) u_core (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr_c),
    .shift_en (shift_c),
    .bit_in   (word_q[DATA_W-1]),
    .pat      (pat_q),
    .pat_len  (len_q),
    .idx      (idx_q),
    .match_c  (match_c)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    pat_d   = pat_q;
    len_d   = len_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    err_d   = err_q;
    hit_d   = 1'b0;
    done_d  = 1'b0;
    clr_c   = 1'b0;
    shift_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          word_d = data_in;
          pat_d  = pat;
          len_d  = pat_len;
          idx_d  = '0;
          cnt_d  = '0;
          err_d  = 1'b0;
          clr_c  = 1'b1;
          if (len_ok_c) begin
            state_d = SHIFT;
            busy_d  = 1'b1;
          end else begin
            state_d = DONE;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end
        end
      end
      SHIFT: begin
        shift_c = 1'b1;
        hit_d   = match_c;
        word_d  = word_q << 1;
        if (match_c) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        if (idx_q == IDX_W'(DATA_W - 1)) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      word_q  <= '0;
      pat_q   <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      hit_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      hit_q   <= hit_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign busy      = busy_q;
  assign hit       = hit_q;
  assign done      = done_q;
  assign match_cnt = cnt_q;
  assign err       = err_q;

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Self-checking bench for seq_scan_ctrl: directed scenarios plus random scans against a bit-list reference model.
module tb_seq_scan_ctrl;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned PAT_W  = 4;
  localparam int unsigned CNT_W  = $clog2(DATA_W + 1);
  localparam int unsigned LEN_W  = $clog2(PAT_W + 1);

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [DATA_W-1:0] data_in;
  logic [PAT_W-1:0]  pat;
  logic [LEN_W-1:0]  pat_len;
  logic              busy, hit, done, err;
  logic [CNT_W-1:0]  match_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_scan_ctrl #(
    .DATA_W (DATA_W),
    .PAT_W  (PAT_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .data_in   (data_in),
    .pat       (pat),
    .pat_len   (pat_len),
    .busy      (busy),
    .hit       (hit),
    .done      (done),
    .match_cnt (match_cnt),
    .err       (err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Bit i of the result is set when the last len scanned bits (oldest = pat[len-1]) equal the pattern.
  function automatic logic [DATA_W-1:0] ref_hits(input logic [DATA_W-1:0] w,
                                                  input logic [PAT_W-1:0] p,
                                                  input int unsigned len);
    logic [DATA_W-1:0] res;
    bit                b [DATA_W];
    bit                ok;
    res = '0;
    for (int i = 0; i < int'(DATA_W); i++) b[i] = w[DATA_W-1-i];
    if (len >= 1 && len <= PAT_W) begin
      for (int i = 0; i < int'(DATA_W); i++) begin
        ok = (i + 1 >= int'(len));
        if (ok) begin
          for (int k = 0; k < int'(len); k++) begin
            if (b[i-k] != p[k]) ok = 0;
          end
        end
        res[i] = ok;
      end
    end
    return res;
  endfunction

  // Launch one scan and check every output cycle by cycle; optionally abort with rst or re-pulse start.
  task automatic scan(input logic [DATA_W-1:0] w, input logic [PAT_W-1:0] p,
                      input int unsigned len, input int abort_at, input bit repulse);
    logic [DATA_W-1:0] eh;
    bit                valid;
    int                exp_cnt;
    int                last;
    bit                e_busy, e_hit, e_done;
    valid   = (len >= 1) && (len <= PAT_W);
    eh      = ref_hits(w, p, len);
    exp_cnt = 0;
    @(negedge clk);
    data_in = w;
    pat     = p;
    pat_len = LEN_W'(len);
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    data_in = ~w;
    last    = valid ? int'(DATA_W) + 2 : 2;
    for (int c = 1; c <= last; c++) begin
      if (c > 1) @(negedge clk);
      if (abort_at > 0 && c == abort_at + 1) begin
        check("rst_busy", 32'(busy), 0);
        check("rst_hit",  32'(hit), 0);
        check("rst_done", 32'(done), 0);
        check("rst_err",  32'(err), 0);
        check("rst_cnt",  32'(match_cnt), 0);
        rst = 1'b0;
        for (int k = 0; k < int'(DATA_W) + 2; k++) begin
          @(negedge clk);
          check("rst_nodone", 32'(done | busy), 0);
        end
        return;
      end
      e_busy = valid && c <= int'(DATA_W);
      e_hit  = valid && c >= 2 && c <= int'(DATA_W) + 1 && eh[c-2];
      if (e_hit) exp_cnt++;
      e_done = valid ? (c == int'(DATA_W) + 1) : (c == 1);
      check("busy", 32'(busy), 32'(e_busy));
      check("hit",  32'(hit),  32'(e_hit));
      check("done", 32'(done), 32'(e_done));
      check("err",  32'(err),  32'(!valid));
      check("cnt",  32'(match_cnt), 32'(exp_cnt));
      if (abort_at > 0 && c == abort_at) rst = 1'b1;
      if (repulse && (c == 5 || c == int'(DATA_W) + 1)) begin
        start   = 1'b1;
        data_in = DATA_W'($urandom);
        pat     = PAT_W'($urandom);
        pat_len = LEN_W'($urandom_range(1, PAT_W));
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
  endtask

  initial begin
    rst     = 1'b1;
    start   = 1'b0;
    data_in = '0;
    pat     = '0;
    pat_len = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", 32'(busy), 0);
    check("reset_hit",  32'(hit), 0);
    check("reset_done", 32'(done), 0);
    check("reset_cnt",  32'(match_cnt), 0);
    check("reset_err",  32'(err), 0);
    rst = 1'b0;

    scan(16'hA5A5, 4'b0101, 3, 0, 0);
    scan(16'hFFFF, 4'b1111, 4, 0, 0);
    scan(16'h0000, 4'b0000, 1, 0, 0);
    scan(16'h1234, 4'b0011, 0, 0, 0);
    scan(16'hA5A5, 4'b0101, 3, 0, 0);
    scan(16'h3C3C, 4'b0110, 4, 0, 1);
    scan(16'hA5A5, 4'b0101, 3, 0, 0);
    scan(16'hA5A5, 4'b0101, 3, 8, 0);
    scan(16'hA5A5, 4'b0101, 3, 0, 0);
    scan(16'hBEEF, 4'b1011, 5, 0, 0);
    scan(16'hBEEF, 4'b1011, 4, 0, 0);

    for (int n = 0; n < 40; n++) begin
      int unsigned l;
      l = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 7) : $urandom_range(1, PAT_W);
      scan(DATA_W'($urandom), PAT_W'($urandom), l, 0, ($urandom_range(0, 4) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_scan_ctrl.md
# seq_scan_ctrl

Frame-level controller for serial pattern detection. It accepts a parallel data word and a programmable pattern (1..PAT_W bits) over a start/busy/done handshake, then shifts the word MSB-first, one bit per cycle, through an overlapping Mealy pattern matcher. It reports a per-bit hit pulse and the final match count. It sits between a register/CPU-side word source and the serial detector datapath, and replaces hand-driving of the single-pattern detector.

## Interface
- DATA_W, 16: bits per scanned word; must be ≥ 2
- PAT_W, 4: maximum pattern length; must be ≥ 1 and ≤ DATA_W
- CNT_W, $clog2(DATA_W+1): match counter width; holds 0..DATA_W
- clk  in  1  single clock, rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  request scan; sampled only in IDLE
- data_in  in  DATA_W  word to scan; captured with start
- pat  in  PAT_W  pattern; pat[pat_len-1] is the first bit in time
- pat_len  in  $clog2(PAT_W+1)  active pattern length; valid range 1..PAT_W
- busy  out  1  scan in progress
- hit  out  1  registered Mealy match pulse, one per matching bit
- done  out  1  one-cycle end-of-scan pulse
- match_cnt  out  CNT_W  matches in the current or last scan
- err  out  1  last request had an invalid pat_len; held until next accepted start

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - start=1 captures data_in, pat, pat_len, and clears the history, bit index, match_cnt and err.
  - Valid pat_len → SHIFT.
  - pat_len=0 or pat_len>PAT_W → DONE with err=1 and match_cnt=0. No bits are shifted.
- SHIFT: one bit per cycle, bit index i=0..DATA_W-1, bit = data word[DATA_W-1-i].
  - History update: h_next = {h[PAT_W-2:0], bit}.
  - match = ((h_next ^ pat) & mask(pat_len)) == 0 AND i+1 ≥ pat_len.
  - Matches overlap; there is no reset of the history after a match.
  - Leave to DONE after i=DATA_W-1.
- DONE: done=1 for exactly one cycle, then → IDLE. start is ignored in DONE.
- start is ignored in SHIFT and DONE. Changing inputs while busy has no effect.
- match_cnt increments on each match. It cannot overflow, because CNT_W covers DATA_W. It holds its value in IDLE.
- Reset values: state IDLE, busy 0, hit 0, done 0, match_cnt 0, err 0, history 0.
- rst mid-scan aborts at the next edge. No done pulse is issued, and match_cnt is zeroed.

## Timing
- start accepted at cycle T.
- busy=1 for cycles T+1..T+DATA_W. busy is 0 in DONE.
- Bit i is evaluated in cycle T+1+i.
- hit for bit i appears at T+2+i. match_cnt includes that match from the same cycle.
- done at T+DATA_W+1. match_cnt is final in that cycle, and the hit for the last bit coincides with done.
- Invalid pat_len: done=1 and err=1 at T+1, busy stays 0.
- Earliest next accepted start: T+DATA_W+2. Back-to-back throughput is DATA_W+2 cycles per word.

## Structure
- Shared package seq_pkg holds:
  - the state enum (IDLE=2'b00, SHIFT=2'b01, DONE=2'b10);
  - the default DATA_W/PAT_W localparams;
  - the mask function mask(len) = (1<<len)-1.
- One sub-module: seq_match_core. It contains the history shift register, the mask compare and the length-qualified combinational match. It is instantiated once.
- seq_scan_ctrl contains the FSM, the capture registers, the bit-index counter, match_cnt, and the hit/done/err output registers.

## Test plan
- data_in=16'hA5A5, pat=4'b0101, pat_len=3 (101), start at T → hit at T+4, T+9, T+12, T+17; done and match_cnt=4 at T+17; busy high T+1..T+16.
- data_in=16'hFFFF, pat=4'b1111, pat_len=4 → first hit at T+5, hits every cycle through T+17, match_cnt=13.
- data_in=16'h0000, pat=4'b0000, pat_len=1 → hit every cycle T+2..T+17, match_cnt=16 (no overflow).
- pat_len=0, start at T → done=1 and err=1 at T+1, busy never asserts, match_cnt=0. The next valid start clears err.
- start re-pulsed at T+5 and at T+17 (DONE) with different data → ignored. The result equals the first scan, and the next scan is accepted only at T+18 or later.
- rst asserted at T+8 of a 16'hA5A5 scan → next cycle state IDLE and all outputs 0, no done pulse. A fresh start then yields match_cnt=4.
